// File: rtl/tim1_cnt_irq.sv
// tim1_cnt_irq: timer 1 prescaler, 16-bit up-counter, auto-reload, CC1 compare and IRQ flags
// TIM1_ARPE_EN selects a shadowed (preloaded) auto-reload register
module tim1_cnt_irq #(
    parameter int CNT_W = 16,
    parameter logic [CNT_W-1:0] ARR_RST = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cen,
    input  logic             i_ug,
    input  logic [CNT_W-1:0] i_psc,
    input  logic [CNT_W-1:0] i_arr,
    input  logic [CNT_W-1:0] i_ccr1,
    input  logic             i_uie,
    input  logic             i_cc1ie,
    input  logic             i_sr_wr,
    input  logic [1:0]       i_sr_wdata,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_uif,
    output logic             o_cc1if,
    output logic             o_irq
);
    logic [CNT_W-1:0] psc_cnt, psc_act, arr_act, cnt_nxt;
    logic tick, wrap, cc1_ev;

    assign tick    = i_cen && psc_cnt == psc_act;
    // Full-scale rollover also counts as an update, for a live ARR lowered below cnt
    assign wrap    = tick && (o_cnt == arr_act || o_cnt == '1);
    assign cnt_nxt = wrap ? '0 : o_cnt + 1'b1;
    assign cc1_ev  = tick && !i_ug && cnt_nxt == i_ccr1 && i_ccr1 <= arr_act;
    assign o_irq   = (o_uif & i_uie) | (o_cc1if & i_cc1ie);

`ifdef TIM1_ARPE_EN
    logic [CNT_W-1:0] arr_sh;
    always_ff @(posedge clk) begin
        if (rst)
            arr_sh <= ARR_RST;
        else if (i_ug || wrap)
            arr_sh <= i_arr;
    end
    assign arr_act = arr_sh;
`else
    assign arr_act = rst ? ARR_RST : i_arr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o_cnt   <= '0;
            psc_cnt <= '0;
            psc_act <= '0;
            o_uif   <= 1'b0;
            o_cc1if <= 1'b0;
        end else begin
            if (i_ug) begin
                o_cnt   <= '0;
                psc_cnt <= '0;
                psc_act <= i_psc;
            end else if (tick) begin
                o_cnt   <= cnt_nxt;
                psc_cnt <= '0;
                psc_act <= wrap ? i_psc : psc_act;
            end else if (i_cen) begin
                psc_cnt <= psc_cnt + 1'b1;
            end
            // rc_w0 clear; a same-cycle set takes priority
            o_uif   <= i_ug || wrap || (o_uif && !(i_sr_wr && !i_sr_wdata[0]));
            o_cc1if <= cc1_ev || (o_cc1if && !(i_sr_wr && !i_sr_wdata[1]));
        end
    end
endmodule

// File: tb/tb_tim1_cnt_irq.sv
// tb_tim1_cnt_irq: directed checks of tim1_cnt_irq counting, flags and interrupt gating
module tb_tim1_cnt_irq;
    logic        clk = 1'b0;
    logic        rst, i_cen, i_ug, i_uie, i_cc1ie, i_sr_wr;
    logic [15:0] i_psc, i_arr, i_ccr1, o_cnt;
    logic [1:0]  i_sr_wdata;
    logic        o_uif, o_cc1if, o_irq;
    int          n_chk = 0;
    int          n_fail = 0;

    tim1_cnt_irq dut (
        .clk(clk), .rst(rst), .i_cen(i_cen), .i_ug(i_ug), .i_psc(i_psc),
        .i_arr(i_arr), .i_ccr1(i_ccr1), .i_uie(i_uie), .i_cc1ie(i_cc1ie),
        .i_sr_wr(i_sr_wr), .i_sr_wdata(i_sr_wdata), .o_cnt(o_cnt),
        .o_uif(o_uif), .o_cc1if(o_cc1if), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int cnt, input int uif, input int cc1if);
        chk({tag, ".cnt"}, 32'(o_cnt), 32'(cnt));
        chk({tag, ".uif"}, 32'(o_uif), 32'(uif));
        chk({tag, ".cc1if"}, 32'(o_cc1if), 32'(cc1if));
    endtask

    initial begin
        rst = 1; i_cen = 0; i_ug = 0; i_psc = 0; i_arr = 4; i_ccr1 = 2;
        i_uie = 1; i_cc1ie = 1; i_sr_wr = 0; i_sr_wdata = 2'b11;
        step(2);
        chk_state("reset", 0, 0, 0);
        chk("reset.irq", 32'(o_irq), 0);
        // basic count with psc=0, arr=4, ccr1=2
        rst = 0; i_cen = 1; i_ug = 1;
        step(1);
        chk_state("ug", 0, 1, 0);
        i_ug = 0;
        step(1);
        chk_state("cnt1", 1, 1, 0);
        i_sr_wr = 1; i_sr_wdata = 2'b10;
        step(1);
        chk_state("cnt2_cc1", 2, 0, 1);
        chk("cnt2.irq", 32'(o_irq), 1);
        i_sr_wr = 0;
        step(1);
        chk("cnt3", 32'(o_cnt), 3);
        step(1);
        chk_state("cnt4", 4, 0, 1);
        step(1);
        chk_state("wrap0", 0, 1, 1);
        // irq gating and rc_w0 clear of UIF only
        i_cc1ie = 0;
        #1;
        chk("irq.uif_only", 32'(o_irq), 1);
        i_sr_wr = 1; i_sr_wdata = 2'b10;
        step(1);
        chk_state("clr_uif", 1, 0, 1);
        chk("clr_uif.irq", 32'(o_irq), 0);
        i_sr_wr = 0; i_cc1ie = 1;
        #1;
        chk("irq.cc1ie_on", 32'(o_irq), 1);
        i_cc1ie = 0;
        #1;
        chk("irq.cc1ie_off", 32'(o_irq), 0);
        chk("cc1if.kept", 32'(o_cc1if), 1);
        // clear coinciding with wrap: set wins
        step(2);
        i_sr_wr = 1; i_sr_wdata = 2'b00;
        step(1);
        chk_state("clr_both", 4, 0, 0);
        step(1);
        chk_state("clr_at_wrap", 0, 1, 0);
        i_sr_wr = 0;
        // ccr1 = 0 fires on wrap
        i_ccr1 = 0; i_sr_wr = 1;
        step(1);
        i_sr_wr = 0;
        step(3);
        chk_state("ccr0.pre", 4, 0, 0);
        step(1);
        chk_state("ccr0.wrap", 0, 1, 1);
        // ccr1 beyond arr never fires
        i_ccr1 = 7; i_sr_wr = 1;
        step(1);
        i_sr_wr = 0;
        step(100);
        chk_state("ccr7.20per", 1, 1, 0);
        // prescaler ratio 3, arr 1
        i_psc = 2; i_arr = 1; i_ug = 1;
        step(1);
        i_ug = 0; i_sr_wr = 1;
        step(1);
        i_sr_wr = 0;
        step(1);
        chk_state("psc.e2", 0, 0, 0);
        step(1);
        chk("psc.e3", 32'(o_cnt), 1);
        step(2);
        chk_state("psc.e5", 1, 0, 0);
        step(1);
        chk_state("psc.e6", 0, 1, 0);
        chk("psc.irq", 32'(o_irq), 1);
        i_sr_wr = 1;
        step(1);
        i_sr_wr = 0;
        step(4);
        chk_state("psc.e11", 1, 0, 0);
        step(1);
        chk_state("psc.e12", 0, 1, 0);
        // ARR change from 9 to 3 while cnt = 5
        i_psc = 0; i_arr = 9; i_ccr1 = 15; i_ug = 1;
        step(1);
        i_ug = 0;
        step(5);
        chk("arr.cnt5", 32'(o_cnt), 5);
        i_arr = 3; i_sr_wr = 1;
        step(1);
        i_sr_wr = 0;
        chk_state("arr.cnt6", 6, 0, 0);
`ifdef TIM1_ARPE_EN
        step(3);
        chk_state("arr.hold9", 9, 0, 0);
`else
        step(65529);
        chk_state("arr.ffff", 16'hFFFF, 0, 0);
`endif
        step(1);
        chk_state("arr.wrap1", 0, 1, 0);
        step(3);
        chk("arr.cnt3", 32'(o_cnt), 3);
        step(1);
        chk("arr.wrap2", 32'(o_cnt), 0);
        // reset mid-count with flags set
        i_ccr1 = 2;
        step(3);
        chk_state("prerst", 3, 1, 1);
        i_cc1ie = 1;
        #1;
        chk("prerst.irq", 32'(o_irq), 1);
        rst = 1; i_cen = 0;
        step(1);
        chk_state("rst", 0, 0, 0);
        chk("rst.irq", 32'(o_irq), 0);
        rst = 0;
        step(3);
        chk("rst.hold", 32'(o_cnt), 0);
        i_cen = 1;
        step(2);
        chk("rst.restart", 32'(o_cnt), 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tim1_cnt_irq.md
Name: tim1_cnt_irq

Overview:
- Timer 1 time-base and interrupt-status stage: prescaler, 16-bit up-counter, auto-reload and channel-1 compare.
- Latches update (UIF) and capture/compare 1 (CC1IF) flags in a status register and gates them with the DIER enables (uie, cc1ie) to drive the timer interrupt line to the NVIC.
- Sits between the bus register file (PSC/ARR/CCR1/SR writes, DIER enable outputs) and the interrupt controller.

Parameters:
- CNT_W, 16, width of counter, prescaler, ARR and CCR1.
- ARR_RST, 16'hFFFF, reset value of the active auto-reload register.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- i_cen  input  1  counter enable (CR1.CEN).
- i_ug  input  1  software update generation; single-cycle pulse.
- i_psc  input  CNT_W  prescaler value; division ratio is i_psc+1.
- i_arr  input  CNT_W  auto-reload value.
- i_ccr1  input  CNT_W  channel-1 compare value.
- i_uie  input  1  update interrupt enable, from DIER.
- i_cc1ie  input  1  CC1 interrupt enable, from DIER.
- i_sr_wr  input  1  status-register write strobe, one cycle.
- i_sr_wdata  input  2  SR write data: bit0 = UIF, bit1 = CC1IF.
- o_cnt  output  CNT_W  current counter value.
- o_uif  output  1  update interrupt flag.
- o_cc1if  output  1  CC1 interrupt flag.
- o_irq  output  1  timer interrupt request.

Behaviour:
- Reset values: cnt = 0, psc_cnt = 0, psc_act = 0, arr_act = ARR_RST, o_uif = 0, o_cc1if = 0, o_irq = 0.
- Tick generation:
  - When i_cen = 1: if psc_cnt == psc_act, then tick = 1 and psc_cnt <= 0; otherwise psc_cnt <= psc_cnt + 1.
  - When i_cen = 0: psc_cnt and cnt hold their values and no tick is generated.
- Counter, on a tick:
  - If cnt == arr_act: cnt <= 0 and an update event (UEV) is raised in the same cycle.
  - Otherwise cnt <= cnt + 1.
- UEV effects: psc_act <= i_psc and UIF is set on the same clock edge. The new ratio applies from the next prescaler period.
- Software update (i_ug = 1): cnt <= 0, psc_cnt <= 0, psc_act <= i_psc, arr_act loads (see the optional feature), UIF set.
  - i_ug overrides any tick in the same cycle.
  - i_ug acts even when i_cen = 0.
- CC1 event:
  - Raised in a tick cycle when the next counter value equals i_ccr1. This includes a wrap to 0 when i_ccr1 = 0.
  - Sets CC1IF.
  - If i_ccr1 > arr_act, the event never fires.
  - An i_ug cycle does not raise a CC1 event.
- ARR = 0: cnt stays at 0 and a UEV occurs on every tick.
- SR write (rc_w0 semantics):
  - When i_sr_wr = 1, each flag whose write-data bit is 0 is cleared; bits written 1 leave the flag unchanged.
  - If a set event and a clear occur in the same cycle, set wins and the flag stays 1.
- Flags are sticky until cleared by software or by rst.
- o_irq = (o_uif & i_uie) | (o_cc1if & i_cc1ie), computed combinationally from the flag flops.
  - o_irq rises in the cycle after the event edge; there is no extra pipeline stage.
  - Deasserting an enable drops o_irq without clearing the flag.
- Reset mid-count: on the rst edge, all state returns to its reset values and any pending event in that cycle is discarded.
- o_cnt is a direct register output.

Optional Feature:
- Macro: TIM1_ARPE_EN (auto-reload preload).
- Defined: arr_act is a shadow register loaded from i_arr only on UEV or i_ug. Changing i_arr mid-period has no effect until the next update.
- Undefined: arr_act follows i_arr combinationally every cycle, with no shadow. The wrap compare uses the live value. If i_arr is lowered below cnt, the counter runs to 2^CNT_W - 1 and wraps to 0 with a UEV.

Test Plan:
- Reset, then i_psc = 0, i_arr = 4, i_ccr1 = 2, i_cen = 1, i_ug pulse → o_uif = 1 the cycle after i_ug; cnt sequence 0,1,2,3,4,0; o_cc1if rises the cycle after the tick where cnt goes 1→2; UIF set again at the 4→0 wrap.
- i_psc = 2, i_arr = 1, flags cleared → cnt increments every 3 clocks; a UEV every 6 clocks once the period is established.
- UIF set, i_uie = 1 → o_irq = 1. Write i_sr_wdata = 2'b10 → UIF cleared, o_irq = 0, CC1IF unchanged. A clear coinciding with a wrap leaves UIF = 1.
- i_ccr1 = 7 with i_arr = 4 → o_cc1if never sets over 20 periods. i_ccr1 = 0 → CC1IF sets on each 4→0 wrap.
- With TIM1_ARPE_EN: change i_arr from 9 to 3 while cnt = 5 → counter still wraps at 9, then at 3. Without it: same stimulus → cnt counts to 0xFFFF and wraps with a UEV.
- rst asserted while cnt = 3 and flags are set → next cycle cnt = 0, o_uif = o_cc1if = o_irq = 0; counting restarts only after i_cen = 1.
